// File: rtl/multi_channel_divider.sv
// Multi-channel programmable divider / PWM timebase with shadowed settings,
// per-channel enable, phase-aligning restart and a wrap tick per channel.
module multi_channel_divider #(
    parameter int CHANNELS       = 4,
    parameter int WIDTH          = 32,
    parameter int DEFAULT_PERIOD = 100000000,
    localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic                sync_start,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic [WIDTH-1:0]    cfg_high,
    output logic [CHANNELS-1:0] square_out,
    output logic [CHANNELS-1:0] tick
);

    localparam logic [WIDTH-1:0] RST_PER = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] RST_HI  = RST_PER >> 1;

    logic cfg_valid;
    assign cfg_valid = cfg_we && (int'(cfg_ch) < CHANNELS);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic             run_q, run_d;
        logic             pend_valid_q, pend_valid_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] per_act_q, per_act_d;
        logic [WIDTH-1:0] hi_act_q, hi_act_d;
        logic [WIDTH-1:0] per_pend_q, per_pend_d;
        logic [WIDTH-1:0] hi_pend_q, hi_pend_d;
        logic             per_nz;
        logic             last_cyc;
        logic             boundary;
        logic             wr_hit;

        always_comb begin
            run_d        = ch_en[i];
            per_nz       = (per_act_q != '0);
            last_cyc     = run_q && per_nz && (cnt_q == per_act_q - WIDTH'(1));
            // Settings may only change where no period is in flight, so the
            // output never sees a runt or stretched pulse.
            boundary     = !run_q || !per_nz || last_cyc || sync_start;
            wr_hit       = cfg_valid && (int'(cfg_ch) == i);
            cnt_d        = boundary ? '0 : cnt_q + WIDTH'(1);
            per_act_d    = per_act_q;
            hi_act_d     = hi_act_q;
            per_pend_d   = per_pend_q;
            hi_pend_d    = hi_pend_q;
            pend_valid_d = pend_valid_q;

            if (wr_hit) begin
                per_pend_d = cfg_period;
                hi_pend_d  = cfg_high;
            end

            if (boundary) begin
                pend_valid_d = 1'b0;
                if (wr_hit) begin
                    per_act_d = cfg_period;
                    hi_act_d  = cfg_high;
                end else if (pend_valid_q) begin
                    per_act_d = per_pend_q;
                    hi_act_d  = hi_pend_q;
                end
            end else if (wr_hit) begin
                pend_valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                run_q        <= 1'b0;
                pend_valid_q <= 1'b0;
                cnt_q        <= '0;
                per_act_q    <= RST_PER;
                hi_act_q     <= RST_HI;
                per_pend_q   <= RST_PER;
                hi_pend_q    <= RST_HI;
            end else begin
                run_q        <= run_d;
                pend_valid_q <= pend_valid_d;
                cnt_q        <= cnt_d;
                per_act_q    <= per_act_d;
                hi_act_q     <= hi_act_d;
                per_pend_q   <= per_pend_d;
                hi_pend_q    <= hi_pend_d;
            end
        end

        assign square_out[i] = run_q && per_nz && (cnt_q < hi_act_q);
        assign tick[i]       = last_cyc;
    end

endmodule

// File: tb/tb_multi_channel_divider.sv
// Bench for multi_channel_divider: directed scenarios plus random traffic,
// every cycle compared against a behavioural per-channel period model.
module tb_multi_channel_divider;

    localparam int NCH  = 5;
    localparam int W    = 16;
    localparam int DEFP = 10;
    localparam int CHW  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] ch_en;
    logic           sync_start;
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [W-1:0]   cfg_period;
    logic [W-1:0]   cfg_high;
    logic [NCH-1:0] square_out;
    logic [NCH-1:0] tick;

    int total = 0;
    int bad   = 0;

    // Model: position within the period, live settings and one staged setting.
    int m_pos[NCH];
    int m_per[NCH];
    int m_hi[NCH];
    int m_sper[NCH];
    int m_shi[NCH];
    bit m_staged[NCH];
    bit m_on[NCH];

    int win_h[NCH];
    int win_t[NCH];
    int win_first[NCH];

    multi_channel_divider #(
        .CHANNELS      (NCH),
        .WIDTH         (W),
        .DEFAULT_PERIOD(DEFP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_en     (ch_en),
        .sync_start(sync_start),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_period(cfg_period),
        .cfg_high  (cfg_high),
        .square_out(square_out),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    function automatic logic [NCH-1:0] exp_sq();
        logic [NCH-1:0] r;
        r = '0;
        for (int c = 0; c < NCH; c++)
            r[c] = m_on[c] && (m_per[c] > 0) && (m_pos[c] < m_hi[c]);
        return r;
    endfunction

    function automatic logic [NCH-1:0] exp_tk();
        logic [NCH-1:0] r;
        r = '0;
        for (int c = 0; c < NCH; c++)
            r[c] = m_on[c] && (m_per[c] > 0) && (m_pos[c] == m_per[c] - 1);
        return r;
    endfunction

    task automatic model_update();
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_pos[c] = 0;      m_per[c] = DEFP;  m_hi[c] = DEFP / 2;
                m_sper[c] = DEFP;  m_shi[c] = DEFP / 2;
                m_staged[c] = 1'b0; m_on[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                automatic bit live  = m_on[c] && (m_per[c] > 0);
                automatic bit ends  = live && (m_pos[c] == m_per[c] - 1);
                automatic bit at_bd = !live || ends || sync_start;
                automatic bit wr    = cfg_we && (int'(cfg_ch) == c);
                m_pos[c] = (live && !ends && !sync_start) ? m_pos[c] + 1 : 0;
                if (at_bd && wr) begin
                    m_per[c] = int'(cfg_period); m_hi[c] = int'(cfg_high);
                    m_staged[c] = 1'b0;
                end else if (at_bd && m_staged[c]) begin
                    m_per[c] = m_sper[c]; m_hi[c] = m_shi[c];
                    m_staged[c] = 1'b0;
                end else if (wr) begin
                    m_sper[c] = int'(cfg_period); m_shi[c] = int'(cfg_high);
                    m_staged[c] = 1'b1;
                end
                m_on[c] = ch_en[c];
            end
        end
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick_clk();
        logic [NCH-1:0] es, et;
        @(posedge clk);
        model_update();
        @(negedge clk);
        cfg_we     = 1'b0;
        sync_start = 1'b0;
        es = exp_sq();
        et = exp_tk();
        total++;
        assert (square_out === es)
        else begin
            bad++;
            $error("FAIL square_out got=%b exp=%b t=%0t", square_out, es, $time);
        end
        total++;
        assert (tick === et)
        else begin
            bad++;
            $error("FAIL tick got=%b exp=%b t=%0t", tick, et, $time);
        end
    endtask

    task automatic set_cfg(input int ch, input int per, input int hi);
        cfg_we     = 1'b1;
        cfg_ch     = CHW'(ch);
        cfg_period = W'(per);
        cfg_high   = W'(hi);
    endtask

    task automatic count_win(input int n);
        for (int c = 0; c < NCH; c++) begin
            win_h[c] = 0; win_t[c] = 0; win_first[c] = 0;
        end
        for (int k = 1; k <= n; k++) begin
            tick_clk();
            for (int c = 0; c < NCH; c++) begin
                win_h[c] += int'(square_out[c]);
                if (tick[c]) begin
                    win_t[c]++;
                    if (win_first[c] == 0) win_first[c] = k;
                end
            end
        end
    endtask

    initial begin
        int g;
        int ft[4];
        for (int c = 0; c < NCH; c++) begin
            m_pos[c] = 0; m_per[c] = 0; m_hi[c] = 0; m_sper[c] = 0; m_shi[c] = 0;
            m_staged[c] = 1'b0; m_on[c] = 1'b0;
        end
        rst = 1'b1; ch_en = '1; sync_start = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_period = '0; cfg_high = '0;

        // Reset held with enables asserted: outputs stay low.
        count_win(3);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("reset_sq%0d", c), win_h[c], 0);
            chk($sformatf("reset_tk%0d", c), win_t[c], 0);
        end

        // Default period 10 on channel 0.
        rst = 1'b0; ch_en = 5'b00001;
        count_win(20);
        chk("def_high", win_h[0], 10);
        chk("def_ticks", win_t[0], 2);
        chk("def_first_tick", win_first[0], 10);

        // Channel 1 at 8/2, rewritten to 4/3 mid-period.
        ch_en = 5'b00011;
        set_cfg(1, 8, 2);
        tick_clk();
        g = 0;
        while (m_pos[1] != 3 && g < 100) begin tick_clk(); g++; end
        chk("wait_ch1_pos3", int'(g < 100), 1);
        set_cfg(1, 4, 3);
        count_win(4);
        chk("mid_tail_high", win_h[1], 0);
        chk("mid_tail_tick", win_first[1], 4);
        count_win(8);
        chk("mid_new_high", win_h[1], 6);
        chk("mid_new_ticks", win_t[1], 2);
        chk("mid_new_first", win_first[1], 4);

        // Write on the wrap cycle bypasses into the very next period.
        g = 0;
        while (!(m_on[1] && m_pos[1] == m_per[1] - 1) && g < 100) begin tick_clk(); g++; end
        chk("wait_ch1_wrap", int'(g < 100), 1);
        set_cfg(1, 6, 1);
        count_win(6);
        chk("bypass_high", win_h[1], 1);
        chk("bypass_tick", win_first[1], 6);

        // Periods 6..9 free running, then a phase-aligning restart.
        ch_en = 5'b01111;
        for (int c = 0; c < 4; c++) begin
            set_cfg(c, 6 + c, 3);
            tick_clk();
        end
        count_win(23);
        sync_start = 1'b1;
        tick_clk();
        chk("sync_sq", int'(square_out[3:0]), 15);
        chk("sync_tk", int'(tick[3:0]), 0);
        for (int c = 0; c < 4; c++) ft[c] = 0;
        for (int k = 2; k <= 12; k++) begin
            tick_clk();
            for (int c = 0; c < 4; c++)
                if (tick[c] && ft[c] == 0) ft[c] = k;
        end
        for (int c = 0; c < 4; c++) chk($sformatf("sync_first%0d", c), ft[c], 6 + c);

        // Edge settings.
        set_cfg(2, 0, 3); tick_clk();
        set_cfg(3, 1, 1); tick_clk();
        set_cfg(0, 5, 5); tick_clk();
        set_cfg(1, 5, 0); tick_clk();
        count_win(12);
        for (int rep = 0; rep < 3; rep++) begin
            if (rep == 1) set_cfg(5, 3, 1);
            if (rep == 2) set_cfg(7, 2, 2);
            if (rep != 0) count_win(12);
            count_win(10);
            chk($sformatf("edge_hi_eq_per_h r%0d", rep), win_h[0], 10);
            chk($sformatf("edge_hi_eq_per_t r%0d", rep), win_t[0], 2);
            chk($sformatf("edge_hi0_h r%0d", rep), win_h[1], 0);
            chk($sformatf("edge_hi0_t r%0d", rep), win_t[1], 2);
            chk($sformatf("edge_per0_h r%0d", rep), win_h[2], 0);
            chk($sformatf("edge_per0_t r%0d", rep), win_t[2], 0);
            chk($sformatf("edge_per1_h r%0d", rep), win_h[3], 10);
            chk($sformatf("edge_per1_t r%0d", rep), win_t[3], 10);
        end

        // Reset mid-period discards a staged write and a simultaneous write.
        g = 0;
        while (m_pos[0] != 1 && g < 100) begin tick_clk(); g++; end
        chk("wait_ch0_pos1", int'(g < 100), 1);
        set_cfg(0, 3, 1);
        tick_clk();
        rst = 1'b1;
        set_cfg(1, 2, 1);
        tick_clk();
        chk("rst_mid_sq", int'(square_out), 0);
        chk("rst_mid_tk", int'(tick), 0);
        rst = 1'b0;
        count_win(10);
        chk("rst_ch0_high", win_h[0], 5);
        chk("rst_ch0_tick", win_first[0], 10);
        chk("rst_ch1_high", win_h[1], 5);
        chk("rst_ch1_ticks", win_t[1], 1);

        // Random traffic against the model.
        ch_en = '1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 19) == 0) ch_en = NCH'($urandom);
            sync_start = ($urandom_range(0, 39) == 0);
            rst        = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 5) == 0) begin
                cfg_we     = 1'b1;
                cfg_ch     = CHW'($urandom_range(0, 7));
                cfg_period = W'($urandom_range(0, 12));
                cfg_high   = W'($urandom_range(0, 14));
            end
            tick_clk();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
